// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel APB timer: register map offsets,
// CTRL bit positions and prescaler geometry.
package timer_pkg;

    // Per-channel register offsets within a channel's 16-byte window
    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_LOAD = 4'h4;
    localparam logic [3:0] OFF_CNT  = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    // Global interrupt status register and channel window size
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h80;
    localparam logic [7:0] CH_STRIDE     = 8'h10;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_PSC_LSB = 3;
    localparam int CTRL_IE      = 6;
    localparam int CTRL_RELOAD  = 7;

    // Prescale select field width and prescaler counter width
    localparam int PSC_W = 3;
    localparam int PRE_W = 7;

    // Prescaler value on which a tick is issued: 2^psc - 1
    function automatic logic [PRE_W-1:0] psc_limit(input logic [PSC_W-1:0] psc);
        return PRE_W'((8'd1 << psc) - 8'd1);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control/reload registers, prescaler, counter and the
// sticky event flag. Bus decode lives in the top; this block only sees strobes.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_ctrl_we,
    input  logic [7:0]       i_ctrl_wdata,
    input  logic             i_load_we,
    input  logic [CNT_W-1:0] i_load_wdata,
    input  logic             i_evt_clr,
    output logic [31:0]      o_ctrl_rd,
    output logic [31:0]      o_load_rd,
    output logic [31:0]      o_cnt_rd,
    output logic             o_evt,
    output logic             o_irq
);

    logic             r_en;
    logic             r_dir;
    logic             r_oneshot;
    logic             r_ie;
    logic [PSC_W-1:0] r_psc;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] r_cnt;
    logic             r_evt;

    logic             w_reload;
    logic             w_tick;
    logic             w_terminal;
    logic             w_event;

    // A reload strobe pre-empts any tick on the same edge, so the event is
    // qualified with it here and the counter process gives reload priority.
    assign w_reload   = i_ctrl_we & i_ctrl_wdata[CTRL_RELOAD];
    assign w_tick     = r_en & (r_pre == psc_limit(r_psc));
    assign w_terminal = r_dir ? (r_cnt == '0) : (r_cnt == r_load);
    assign w_event    = w_tick & ~w_reload & w_terminal;

    // Prescaler: held at zero while disabled, restarts after every tick
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_pre <= '0;
        end else if (!r_en || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Counter: reload strobe first, then terminal handling, then step
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_cnt <= '0;
        end else if (w_reload) begin
            r_cnt <= r_load;
        end else if (w_tick) begin
            if (w_terminal) begin
                // one-shot parks on the terminal value
                if (!r_oneshot) begin
                    r_cnt <= r_dir ? r_load : '0;
                end
            end else begin
                r_cnt <= r_dir ? (r_cnt - CNT_W'(1)) : (r_cnt + CNT_W'(1));
            end
        end
    end

    // Control fields: a bus write overrides the one-shot auto-disable
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_en      <= 1'b0;
            r_dir     <= 1'b0;
            r_oneshot <= 1'b0;
            r_psc     <= '0;
            r_ie      <= 1'b0;
        end else if (i_ctrl_we) begin
            r_en      <= i_ctrl_wdata[CTRL_EN];
            r_dir     <= i_ctrl_wdata[CTRL_DIR];
            r_oneshot <= i_ctrl_wdata[CTRL_ONESHOT];
            r_psc     <= i_ctrl_wdata[CTRL_PSC_LSB +: PSC_W];
            r_ie      <= i_ctrl_wdata[CTRL_IE];
        end else if (w_event && r_oneshot) begin
            r_en <= 1'b0;
        end
    end

    // Reload value register
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_load <= '0;
        end else if (i_load_we) begin
            r_load <= i_load_wdata;
        end
    end

    // Sticky event flag: a new event beats a simultaneous write-1-to-clear
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_evt <= 1'b0;
        end else if (w_event) begin
            r_evt <= 1'b1;
        end else if (i_evt_clr) begin
            r_evt <= 1'b0;
        end
    end

    assign o_ctrl_rd = 32'({r_ie, r_psc, r_oneshot, r_dir, r_en});
    assign o_load_rd = 32'(r_load);
    assign o_cnt_rd  = 32'(r_cnt);
    assign o_evt     = r_evt;
    assign o_irq     = r_evt & r_ie;

endmodule

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: zero-wait APB slave with address decode, error
// detection, read mux and IRQ_STAT; the channels do the counting.
module apb_timer_mc
    import timer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic            PWRITE,
    input  logic [7:0]      PADDR,
    input  logic [31:0]     PWDATA,
    output logic [31:0]     PRDATA,
    output logic            PREADY,
    output logic            PSLVERR,
    output logic [N_CH-1:0] irq
);

    logic            w_access;
    logic            w_err;
    logic            w_wr_ok;
    logic            w_ch_valid;
    logic [3:0]      w_ch_idx;
    logic [3:0]      w_off;
    logic [31:0]     w_rd_word;
    logic [N_CH-1:0] w_evt;
    logic [31:0]     w_ctrl_rd [N_CH];
    logic [31:0]     w_load_rd [N_CH];
    logic [31:0]     w_cnt_rd  [N_CH];
    logic            w_unused_pwdata;

    assign w_access   = PSEL & PENABLE;
    assign w_ch_idx   = 4'(PADDR / CH_STRIDE);
    assign w_off      = 4'(PADDR % CH_STRIDE);
    assign w_ch_valid = int'(w_ch_idx) < N_CH;

    // Upper write-data bits are only meaningful for wide counters
    assign w_unused_pwdata = ^PWDATA;

    // Address decode: flags illegal accesses and selects the read word
    always_comb begin
        w_err     = 1'b0;
        w_rd_word = '0;
        if (PADDR[1:0] != 2'b00) begin
            w_err = 1'b1;
        end else if (PADDR == ADDR_IRQ_STAT) begin
            if (PWRITE) begin
                w_err = 1'b1;
            end else begin
                w_rd_word = 32'(w_evt);
            end
        end else if (!w_ch_valid) begin
            w_err = 1'b1;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_ch_idx == 4'(c)) begin
                    case (w_off)
                        OFF_CTRL: w_rd_word = w_ctrl_rd[c];
                        OFF_LOAD: w_rd_word = w_load_rd[c];
                        OFF_CNT: begin
                            w_rd_word = w_cnt_rd[c];
                            if (PWRITE) begin
                                w_err = 1'b1;
                            end
                        end
                        OFF_STAT: w_rd_word = 32'(w_evt[c]);
                        default:  w_err = 1'b1;
                    endcase
                end
            end
        end
    end

    assign w_wr_ok = w_access & PWRITE & ~w_err;
    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & w_err;
    assign PRDATA  = (w_access & ~PWRITE & ~w_err) ? w_rd_word : 32'd0;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic w_hit;
        assign w_hit = w_wr_ok & (w_ch_idx == 4'(gi));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .i_clk        (PCLK),
            .i_srst       (PRESET),
            .i_ctrl_we    (w_hit & (w_off == OFF_CTRL)),
            .i_ctrl_wdata (PWDATA[7:0]),
            .i_load_we    (w_hit & (w_off == OFF_LOAD)),
            .i_load_wdata (PWDATA[CNT_W-1:0]),
            .i_evt_clr    (w_hit & (w_off == OFF_STAT) & PWDATA[0]),
            .o_ctrl_rd    (w_ctrl_rd[gi]),
            .o_load_rd    (w_load_rd[gi]),
            .o_cnt_rd     (w_cnt_rd[gi]),
            .o_evt        (w_evt[gi]),
            .o_irq        (irq[gi])
        );
    end

endmodule

// File: tb/tb_apb_timer_mc.sv
// Bench for apb_timer_mc: randomized APB traffic against a behavioural model
// of the timer rules, plus a 32-bit single-channel instance for the wrap case.
module tb_apb_timer_mc;

    localparam int N = 4;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [N-1:0] irq;

    logic        q_psel = 1'b0, q_penable = 1'b0, q_pwrite = 1'b0;
    logic [7:0]  q_paddr = '0;
    logic [31:0] q_pwdata = '0;
    logic [31:0] q_prdata;
    logic        q_pready, q_pslverr;
    logic [0:0]  q_irq;

    int n_checks = 0;
    int n_pass   = 0;

    apb_timer_mc #(.N_CH(N), .CNT_W(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .irq(irq)
    );

    apb_timer_mc #(.N_CH(1), .CNT_W(32)) dut32 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(q_psel), .PENABLE(q_penable),
        .PWRITE(q_pwrite), .PADDR(q_paddr), .PWDATA(q_pwdata), .PRDATA(q_prdata),
        .PREADY(q_pready), .PSLVERR(q_pslverr), .irq(q_irq)
    );

    always #5 PCLK = ~PCLK;

    // Reference model state, one entry per channel
    bit          m_en [N], m_dir [N], m_one [N], m_ie [N], m_evt [N];
    int          m_psc [N];
    int          m_elapsed [N];
    logic [15:0] m_load [N], m_cnt [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit exp_err(input logic [7:0] a, input bit wr);
        if (a[1:0] != 2'b00) return 1'b1;
        if (a == 8'h80) return wr;
        if (int'(a[7:4]) >= N) return 1'b1;
        if (a[3:0] == 4'h8 && wr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_en[c] = 0; m_dir[c] = 0; m_one[c] = 0; m_ie[c] = 0; m_evt[c] = 0;
            m_psc[c] = 0; m_elapsed[c] = 0; m_load[c] = '0; m_cnt[c] = '0;
        end
    endfunction

    // Advance the model by one clock edge using the bus values at that edge
    function automatic void model_step();
        bit wr_ok;
        int ch, off;
        if (PRESET) begin
            model_reset();
            return;
        end
        wr_ok = PSEL && PENABLE && PWRITE && !exp_err(PADDR, 1'b1);
        ch  = int'(PADDR) / 16;
        off = int'(PADDR) % 16;
        for (int c = 0; c < N; c++) begin
            bit hit, reload, tick, set;
            int period;
            hit    = wr_ok && (ch == c);
            reload = hit && (off == 0) && PWDATA[7];
            period = 1 << m_psc[c];
            tick   = m_en[c] && ((m_elapsed[c] % period) == period - 1);
            m_elapsed[c] = m_en[c] ? m_elapsed[c] + 1 : 0;
            set = 0;
            if (reload) begin
                m_cnt[c] = m_load[c];
            end else if (tick) begin
                if (!m_dir[c]) begin
                    if (m_cnt[c] == m_load[c]) begin
                        set = 1;
                        if (m_one[c]) m_en[c] = 0; else m_cnt[c] = 16'd0;
                    end else begin
                        m_cnt[c] = m_cnt[c] + 16'd1;
                    end
                end else begin
                    if (m_cnt[c] == 16'd0) begin
                        set = 1;
                        if (m_one[c]) m_en[c] = 0; else m_cnt[c] = m_load[c];
                    end else begin
                        m_cnt[c] = m_cnt[c] - 16'd1;
                    end
                end
            end
            if (set) m_evt[c] = 1;
            else if (hit && off == 12 && PWDATA[0]) m_evt[c] = 0;
            if (hit && off == 0) begin
                m_en[c]  = PWDATA[0];
                m_dir[c] = PWDATA[1];
                m_one[c] = PWDATA[2];
                m_psc[c] = int'(PWDATA[5:3]);
                m_ie[c]  = PWDATA[6];
            end
            if (hit && off == 4) m_load[c] = PWDATA[15:0];
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] r;
        int c;
        r = '0;
        if (exp_err(a, 1'b0)) return 32'd0;
        if (a == 8'h80) begin
            for (int k = 0; k < N; k++) r[k] = m_evt[k];
            return r;
        end
        c = int'(a[7:4]);
        case (a[3:0])
            4'h0: r = {25'd0, m_ie[c], 3'(m_psc[c]), m_one[c], m_dir[c], m_en[c]};
            4'h4: r = 32'(m_load[c]);
            4'h8: r = 32'(m_cnt[c]);
            default: r = 32'(m_evt[c]);
        endcase
        return r;
    endfunction

    function automatic logic [31:0] model_irq();
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < N; c++) r[c] = m_evt[c] & m_ie[c];
        return r;
    endfunction

    // One clock: compare irq before the edge, step the model at the edge
    task automatic tick_clk();
        if (!PRESET) check("irq", 32'(irq), model_irq());
        @(posedge PCLK);
        model_step();
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        tick_clk();
        PENABLE = 1;
        #3;
        e = PSLVERR;
        check($sformatf("wr_err_%h", a), 32'(e), 32'(exp_err(a, 1'b1)));
        check("pready", 32'(PREADY), 32'd1);
        tick_clk();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        $display("WR addr=%h data=%h err=%0b", a, d, e);
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        tick_clk();
        PENABLE = 1;
        #3;
        d = PRDATA;
        e = PSLVERR;
        check($sformatf("rd_data_%h", a), d, model_read(a));
        check($sformatf("rd_err_%h", a), 32'(e), 32'(exp_err(a, 1'b0)));
        tick_clk();
        PSEL = 0; PENABLE = 0;
        $display("RD addr=%h data=%h err=%0b", a, d, e);
    endtask

    task automatic q_write(input logic [7:0] a, input logic [31:0] d);
        q_psel = 1; q_penable = 0; q_pwrite = 1; q_paddr = a; q_pwdata = d;
        tick_clk();
        q_penable = 1;
        #3;
        check("q_wr_err", 32'(q_pslverr), 32'd0);
        tick_clk();
        q_psel = 0; q_penable = 0; q_pwrite = 0;
        $display("WR32 addr=%h data=%h", a, d);
    endtask

    task automatic q_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        q_psel = 1; q_penable = 0; q_pwrite = 0; q_paddr = a;
        tick_clk();
        q_penable = 1;
        #3;
        d = q_prdata;
        e = q_pslverr;
        tick_clk();
        q_psel = 0; q_penable = 0;
        $display("RD32 addr=%h data=%h err=%0b", a, d, e);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lv, ctrl, op, ch;
        logic [7:0]  a;

        // Reset for two cycles
        model_reset();
        PRESET = 1;
        tick_clk();
        tick_clk();
        PRESET = 0;
        #3;
        check("rst_pready", 32'(PREADY), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_prdata_idle", PRDATA, 32'd0);
        check("rst_pslverr_idle", 32'(PSLVERR), 32'd0);
        for (int c = 0; c < N; c++) begin
            for (int o = 0; o < 16; o += 4) apb_read(8'(c * 16 + o), d, e);
        end
        apb_read(8'h80, d, e);
        apb_read(8'h90, d, e);
        check("rst_0x90_err", 32'(e), 32'd1);
        check("rst_0x90_data", d, 32'd0);

        // Periodic up count on channel 0
        apb_write(8'h04, 32'd3, e);
        apb_write(8'h00, 32'h41, e);
        apb_read(8'h08, d, e);
        check("ch0_first_cnt", d, 32'd1);
        for (int i = 0; i < 6; i++) apb_read(8'h08, d, e);
        apb_write(8'h0C, 32'd1, e);
        for (int i = 0; i < 6; i++) tick_clk();
        apb_write(8'h00, 32'h0, e);
        apb_write(8'h0C, 32'd1, e);
        apb_read(8'h0C, d, e);
        check("ch0_stat_cleared", d, 32'd0);

        // Down one-shot with prescale 4 on channel 1
        apb_write(8'h14, 32'd2, e);
        apb_write(8'h10, 32'h80, e);
        apb_read(8'h18, d, e);
        check("ch1_preload", d, 32'd2);
        apb_write(8'h10, 32'h17, e);
        for (int i = 0; i < 10; i++) apb_read(8'h18, d, e);
        apb_read(8'h10, d, e);
        check("ch1_done_ctrl", d, 32'h16);
        apb_read(8'h18, d, e);
        check("ch1_done_cnt", d, 32'd0);
        apb_read(8'h1C, d, e);
        check("ch1_done_evt", d, 32'd1);

        // W1C colliding with an event every tick (LOAD=0)
        apb_write(8'h20, 32'h41, e);
        tick_clk();
        apb_write(8'h2C, 32'd1, e);
        check("w1c_vs_evt_irq", 32'(irq[2]), 32'd1);
        apb_read(8'h2C, d, e);
        check("w1c_vs_evt_stat", d, 32'd1);
        apb_write(8'h20, 32'h0, e);
        apb_write(8'h2C, 32'd1, e);

        // RELOAD strobe on a tick edge discards the tick
        apb_write(8'h34, 32'd100, e);
        apb_write(8'h30, 32'h82, e);
        apb_write(8'h30, 32'h03, e);
        for (int i = 0; i < 3; i++) tick_clk();
        apb_write(8'h30, 32'h83, e);
        apb_read(8'h38, d, e);
        check("reload_vs_tick_cnt", d, 32'd99);
        apb_read(8'h3C, d, e);
        check("reload_vs_tick_evt", d, 32'd0);
        apb_write(8'h30, 32'h0, e);

        // Error responses leave state untouched
        apb_write(8'h08, 32'h1234, e);
        check("err_wr_cnt", 32'(e), 32'd1);
        apb_write(8'h01, 32'hFF, e);
        check("err_unaligned", 32'(e), 32'd1);
        apb_write(8'h40, 32'h41, e);
        check("err_ch_range", 32'(e), 32'd1);
        apb_write(8'h80, 32'hF, e);
        apb_read(8'h08, d, e);
        apb_read(8'h00, d, e);
        apb_read(8'h42, d, e);
        apb_read(8'h80, d, e);

        // 32-bit single-channel instance: all-ones wrap with event
        q_write(8'h04, 32'hFFFF_FFFF);
        q_write(8'h00, 32'h80);
        q_read(8'h08, d, e);
        check("w32_preload", d, 32'hFFFF_FFFF);
        q_write(8'h00, 32'h41);
        q_read(8'h08, d, e);
        check("w32_wrap_cnt", d, 32'd0);
        q_read(8'h0C, d, e);
        check("w32_wrap_evt", d, 32'd1);
        check("w32_irq", 32'(q_irq), 32'd1);
        q_read(8'h10, d, e);
        check("w32_ch_range_err", 32'(e), 32'd1);
        check("w32_ch_range_data", d, 32'd0);
        q_write(8'h00, 32'h0);

        // Independent channels with random reload values and direction
        for (int c = 0; c < N; c++) begin
            lv = int'($urandom_range(1, 9));
            apb_write(8'(c * 16 + 4), 32'(lv), e);
            ctrl = 1 | (int'($urandom_range(0, 1)) << 1) | (c << 3) | (1 << 6);
            apb_write(8'(c * 16), 32'(ctrl), e);
        end
        for (int i = 0; i < 100; i++) begin
            op = int'($urandom_range(0, 3));
            ch = int'($urandom_range(0, N - 1));
            case (op)
                0: begin tick_clk(); tick_clk(); end
                1: apb_read(8'h80, d, e);
                2: begin
                    a = 8'(ch * 16 + ($urandom_range(0, 1) == 0 ? 8 : 12));
                    apb_read(a, d, e);
                end
                default: apb_write(8'(ch * 16 + 12), 32'd1, e);
            endcase
        end

        // Reset while everything is counting
        PRESET = 1;
        tick_clk();
        PRESET = 0;
        #3;
        check("midrst_irq", 32'(irq), 32'd0);
        apb_read(8'h08, d, e);
        check("midrst_cnt0", d, 32'd0);
        apb_read(8'h30, d, e);
        apb_read(8'h80, d, e);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_timer_mc.md
# apb_timer_mc

Multi-channel, width-parametrised APB timer and the successor to the single-channel 8-bit timer. It provides N_CH independent channels, each with its own control, reload, count and status registers. Each channel has a per-channel power-of-two prescaler, up or down counting, periodic or one-shot mode, and a level interrupt. It sits on the peripheral APB bus as a zero-wait-state slave, with all logic on one clock and no external clock inputs.

## Interface
- N_CH, 4, number of channels (1..8)
- CNT_W, 16, counter/reload width in bits (1..32); register fields zero-extended to 32 bits on read
- PCLK  in  1  bus and timer clock
- PRESET  in  1  reset, synchronous, active-high
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  8  byte address
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- irq  out  N_CH  per-channel interrupt, level

## Operation
- Register map: channel c at base c*0x10. Offsets:
  - +0x0 CTRL rw
  - +0x4 LOAD rw (CNT_W bits)
  - +0x8 CNT ro
  - +0xC STAT (bit0 EVT, write-1-to-clear)
- 0x80 IRQ_STAT ro: bit c = EVT of channel c.
- CTRL bits:
  - [0] EN
  - [1] DIR (0 up, 1 down)
  - [2] ONESHOT
  - [5:3] PSC
  - [6] IE
  - [7] RELOAD: write-1 strobe; CNT←LOAD for up, CNT←LOAD for down too; always reads 0
- Prescaler: 7-bit per channel, held at 0 while EN=0. A tick occurs when the prescaler equals 2^PSC−1, and the prescaler then returns to 0. PSC=0 gives a tick every cycle.
- Up count on each tick:
  - CNT==LOAD: CNT←0, EVT←1.
  - Otherwise CNT←CNT+1, wrapping mod 2^CNT_W. An all-ones→0 rollover with CNT>LOAD sets no EVT.
- Down count on each tick:
  - CNT==0: CNT←LOAD, EVT←1.
  - Otherwise CNT←CNT−1.
- One-shot: on the event tick, EVT←1 and EN←0. CNT holds its terminal value instead: LOAD for up, 0 for down.
- irq[c] = EVT[c] & IE[c].
- LOAD writes take effect immediately; the comparison always uses the current LOAD.
- PSLVERR=1 in the access phase, with no register change, for any of:
  - PADDR[1:0]≠0
  - channel index ≥ N_CH
  - offset not in the map
  - write to CNT or IRQ_STAT
- Errored reads return PRDATA=0.

## Timing
- PREADY is tied to 1; every transfer completes in its first access cycle (PSEL&PENABLE).
- Writes commit at the PCLK edge ending the access phase and are visible to reads and to counting from the next cycle.
- PRDATA is combinational from PADDR during PSEL&PENABLE&!PWRITE, and 0 otherwise. PSLVERR is combinational and valid only in the access phase.
- irq is combinational from registered EVT/IE, so it rises the cycle after the event edge.
- Reset values:
  - All registers 0 (EN=0, LOAD=0, CNT=0, EVT=0); prescalers 0.
  - PRDATA=0, PSLVERR=0, PREADY=1, irq=0.
- Reset mid-count: state is cleared on the next PCLK edge with PRESET=1; no tick or event is produced in that cycle.
- Simultaneous events on the same edge:
  - A STAT W1C and a new event: the set wins, and EVT stays 1.
  - A RELOAD strobe and a tick: the reload wins and the tick is discarded, with no EVT.
  - A CTRL write setting EN and a tick: the tick is impossible, since the prescaler was held at 0.
  - A CTRL write clearing EN on an event tick: the write wins and EN=0, but EVT and CNT still update from the tick.
- LOAD=0: up mode stays at 0 with an event every tick; down mode behaves the same.

## Structure
- Shared package timer_pkg:
  - register offsets (CTRL/LOAD/CNT/STAT/IRQ_STAT)
  - channel stride
  - CTRL bit-position constants
  - PSC field width
- Sub-module timer_channel, instantiated N_CH times: holds the prescaler, counter, EVT, CTRL/LOAD registers and the tick/event logic. It takes decoded write strobes and data from the top.
- The top does the APB decode, the error check, the read mux and IRQ_STAT.

## Test plan
- Reset:
  - Apply PRESET=1 for 2 cycles.
  - Every register reads 0, irq=0, PREADY=1.
  - Read of 0x90 → PSLVERR=1, PRDATA=0.
- Periodic up:
  - Ch0 LOAD=3, CTRL=EN|IE (PSC=0).
  - CNT sequence is 1,2,3,0,1…; EVT and irq[0] rise the cycle after 3→0.
  - W1C on STAT clears irq.
- Down one-shot with prescale:
  - Ch1 LOAD=2, CTRL=EN|DIR|ONESHOT|PSC=2; preload with a RELOAD strobe first.
  - CNT decrements every 4 cycles (2,1,0), then EN reads 0 and CNT stays 0.
- Simultaneous events:
  - W1C to STAT on the same edge as an event: EVT stays 1.
  - RELOAD strobe on a tick edge: CNT=LOAD and no EVT.
- Errors:
  - Write to CNT, PADDR=0x01, and channel N_CH base address: each gives PSLVERR=1 with state unchanged.
  - Second instance with CNT_W=32, N_CH=1: CNT wraps 0xFFFFFFFF→0 when LOAD=0xFFFFFFFF, with EVT=1.
- Multi-channel independence:
  - 4 channels with different LOAD/PSC running together.
  - IRQ_STAT bits and the irq vector match each channel's reference period exactly over 200 cycles.
